spi_rx_slave: RTL and testbench

- Receive-side SPI stage downstream of the team's 12-bit SPI transmitter; consumes its cs/sclk/mosi pins.
- Oversamples all three pins on the system clock, with no sclk-domain logic.
- Reassembles each LSB-first word and presents it on a valid/ready holding register to the consuming logic.
- Flags short frames and unacknowledged-word overruns.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_rx_slave_if.sv | 28 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_rx_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_rx_slave.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width (common with the 12-bit
// transmitter), receiver state encodings and the counter sizing helper.
package spi_pkg;

    localparam int SPI_DATA_W      = 12;
    localparam int SPI_LEAD_EDGES  = 1;
    localparam int SPI_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TAIL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEAD  = ST_LEAD,
        SHIFT = ST_SHIFT,
        TAIL  = ST_TAIL
    } rx_state_t;

    // One counter serves both the lead-edge count and the bit count, so it
    // must be wide enough for whichever limit is larger.
    function automatic int cnt_width(input int data_w, input int lead_edges);
        int top_val;
        top_val = (data_w > lead_edges) ? data_w : lead_edges;
        return $clog2(top_val + 1);
    endfunction

endpackage

// File: rtl/spi_rx_slave_if.sv
// Pin and consumer-side bundle of the SPI receive stage.
interface spi_rx_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    // Transmitter + consumer side.
    modport master (
        output cs, sclk, mosi, dout_ready,
        input  dout, dout_valid, busy, frame_err, overrun
    );

    // Receiver side.
    modport slave (
        input  cs, sclk, mosi, dout_ready,
        output dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with one history flop and rise/fall event outputs.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the asynchronous pin through the chain; history trails the output by one clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = ~hist_q & sync_o;
    assign fall_o = hist_q & ~sync_o;

endmodule

// File: rtl/spi_rx_slave.sv
// Oversampling SPI receiver: reassembles LSB-first words from cs/sclk/mosi
// and holds each completed word on a valid/ready register.
module spi_rx_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int LEAD_EDGES  = SPI_LEAD_EDGES,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input logic           clk,
    input logic           rst_n,
    spi_rx_slave_if.slave bus
);
    localparam int CNT_W    = cnt_width(DATA_W, LEAD_EDGES);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_fall, sclk_sync_unused, sclk_rise_unused;
    logic mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.cs),
        .sync_o (cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.sclk),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise_unused),
        .fall_o (sclk_fall)
    );

    // mosi uses the same depth as sclk so the bit seen with sclk_fall is the
    // one the pin held when sclk fell.
    logic [SYNC_STAGES-1:0] mosi_q;

    // Plain synchroniser chain for mosi (no edge detection needed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    // A reset taken while cs is low would make the synchronised cs fall from
    // its idle reset value and look like a new frame. Frames are only
    // accepted once the chain holds real samples and cs has been seen high.
    logic [SETTLE_W-1:0] settle_q;
    logic                armed_q;

    // Track synchroniser fill after reset and arm on the first idle-high cs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SETTLE_W'(SYNC_STAGES)) begin
                settle_q <= settle_q + 1'b1;
            end
            if ((settle_q == SETTLE_W'(SYNC_STAGES)) && cs_sync) begin
                armed_q <= 1'b1;
            end
        end
    end

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              accept;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic: frame sequencing, word completion and handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        dout_d       = dout_q;
        accept       = dout_valid_q & bus.dout_ready;
        dout_valid_d = dout_valid_q & ~accept;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;
        cnt_inc      = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    cnt_d = '0;
                    if (LEAD_EDGES == 0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = LEAD;
                    end
                end
            end
            LEAD: begin
                // cs_rise takes priority over a coincident sclk edge.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_fall) begin
                    if (cnt_inc == CNT_W'(LEAD_EDGES)) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_fall) begin
                    sr_d  = {mosi_sync, sr_q[DATA_W-1:1]};
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DATA_W)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // The trailing sclk edge is ignored; only cs_rise matters.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (!dout_valid_q || accept) begin
                        dout_d       = sr_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_rx_slave.sv
// Randomised scoreboard bench for spi_rx_slave: frames are driven like the
// 12-bit transmitter, expected outcomes are queued, a monitor compares them.
module tb_spi_rx_slave;
    import spi_pkg::*;

    localparam int HP = 11;  // sclk half period in clk cycles

    typedef struct {
        bit          is_err;
        logic [11:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    spi_rx_slave_if #(.DATA_W(12)) bus ();

    spi_rx_slave #(.DATA_W(12), .LEAD_EDGES(1), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    bit          model_valid   = 1'b0;
    bit          model_overrun = 1'b0;
    logic [11:0] model_dout    = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit v);
        bus.dout_ready = v;
        if (v) model_valid = 1'b0;
        wait_clks(2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},       32'(bus.dout),       32'h0);
        chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'h0);
        chk({tag, "_busy"},       32'(bus.busy),       32'h0);
        chk({tag, "_frame_err"},  32'(bus.frame_err),  32'h0);
        chk({tag, "_overrun"},    32'(bus.overrun),    32'h0);
    endtask

    // Drives one transmitter-style frame; the expected outcome is decided
    // up front from the frame description alone.
    task automatic send_frame(input logic [11:0] data, input int nbits, input bit trailing,
                              input bit align, input int rst_at, input bit pulse_ready,
                              input bit chk_lat);
        exp_t e;
        if (rst_at >= 0) begin
            model_valid   = 1'b0;
            model_overrun = 1'b0;
            model_dout    = '0;
        end else if (nbits >= 12) begin
            if (!model_valid || bus.dout_ready || pulse_ready) begin
                e.is_err = 1'b0;
                e.data   = data;
                sb.push_back(e);
                model_dout  = data;
                model_valid = !bus.dout_ready;
            end else begin
                model_overrun = 1'b1;
            end
        end else begin
            e.is_err = 1'b1;
            e.data   = '0;
            sb.push_back(e);
        end

        // cs leads bit 0 by one full sclk cycle whose falling edge is discarded.
        bus.cs = 1'b0;
        wait_clks(HP);
        bus.sclk = 1'b1;
        wait_clks(HP);
        bus.sclk = 1'b0;
        wait_clks(HP);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                chk_all_zero("midreset");
            end
            bus.sclk = 1'b1;
            bus.mosi = data[i];
            wait_clks(HP);
            bus.sclk = 1'b0;
            wait_clks(HP);
        end
        if (align) begin
            bus.sclk = 1'b1;
            bus.mosi = 1'b0;
            wait_clks(HP);
            bus.sclk = 1'b0;
            bus.cs   = 1'b1;
        end else begin
            if (trailing) begin
                bus.sclk = 1'b1;
                bus.mosi = 1'b0;
                wait_clks(HP);
                bus.sclk = 1'b0;
                wait_clks(HP);
            end
            bus.cs = 1'b1;
        end

        if (chk_lat) begin
            repeat (2) @(posedge clk);
            #1;
            chk("lat_valid_edge2", 32'(bus.dout_valid), 32'h0);
            @(posedge clk);
            #1;
            chk("lat_valid_edge3", 32'(bus.dout_valid), 32'h1);
            chk("lat_dout_edge3",  32'(bus.dout),       32'(data));
            chk("lat_ferr_edge3",  32'(bus.frame_err),  32'h0);
            @(posedge clk);
            #1;
            chk("lat_valid_edge4", 32'(bus.dout_valid), 32'h0);
        end
        if (pulse_ready) begin
            repeat (2) @(posedge clk);
            #1;
            bus.dout_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.dout_ready = 1'b0;
        end

        wait_clks(8);
        chk("post_busy",    32'(bus.busy),       32'h0);
        chk("post_valid",   32'(bus.dout_valid), 32'(model_valid));
        chk("post_overrun", 32'(bus.overrun),    32'(model_overrun));
        chk("post_dout",    32'(bus.dout),       32'(model_dout));
        wait_clks(4);
    endtask

    // Monitor: every newly presented word and every error pulse pops one
    // expectation from the scoreboard.
    initial begin
        exp_t e;
        bit   prev_valid = 1'b0;
        bit   prev_xfer  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
            end else begin
                if (bus.frame_err) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_err: got unexpected pulse, want no event");
                    end else begin
                        e = sb.pop_front();
                        if (!e.is_err) begin
                            miscompares++;
                            $display("FAIL frame_err: got error pulse, want word %h", e.data);
                        end
                    end
                end
                if (bus.dout_valid && (!prev_valid || prev_xfer)) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL word: got unexpected word %h, want no event", bus.dout);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_err) begin
                            miscompares++;
                            $display("FAIL word: got word %h, want error pulse", bus.dout);
                        end else if (bus.dout !== e.data) begin
                            miscompares++;
                            $display("FAIL word: got %h want %h", bus.dout, e.data);
                        end
                    end
                end
                prev_valid = bus.dout_valid;
                prev_xfer  = bus.dout_valid && bus.dout_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rdata;
        int          nb;
        rst_n          = 1'b0;
        bus.cs         = 1'b1;
        bus.sclk       = 1'b0;
        bus.mosi       = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_clks(10);

        // Transmitter-accurate frame with latency checks.
        set_ready(1'b1);
        send_frame(12'hA5C, 12, 1'b1, 1'b0, -1, 1'b0, 1'b1);

        // Unacknowledged word followed by a second one -> overrun.
        set_ready(1'b0);
        send_frame(12'h123, 12, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        send_frame(12'hFFF, 12, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        set_ready(1'b1);
        wait_clks(2);
        chk("ovr_accept_valid", 32'(bus.dout_valid), 32'h0);
        chk("ovr_accept_dout",  32'(bus.dout),       32'h123);

        // Short frame, then a good one.
        send_frame(12'h3A7, 6, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        send_frame(12'h0F0, 12, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // Reset mid-shift, then a good frame.
        send_frame(12'h555, 12, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        send_frame(12'h3C3, 12, 1'b1, 1'b0, -1, 1'b0, 1'b0);

        // Accept and reload in the same cycle.
        set_ready(1'b0);
        send_frame(12'h001, 12, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        send_frame(12'h800, 12, 1'b1, 1'b0, -1, 1'b1, 1'b0);
        set_ready(1'b1);

        // cs rise coincident with the trailing sclk fall.
        send_frame(12'h6A9, 12, 1'b0, 1'b1, -1, 1'b0, 1'b0);

        // Randomised frames and consumer readiness.
        for (int k = 0; k < 12; k++) begin
            set_ready(1'($urandom_range(0, 1)));
            rdata = 12'($urandom_range(0, 4095));
            nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : 12;
            send_frame(rdata, nb, nb == 12, 1'b0, -1, 1'b0, 1'b0);
        end

        set_ready(1'b1);
        wait_clks(20);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
